rf_write_arbiter: RTL and testbench

- Shares the single register-file write port between two writers:
  - primary: pipeline writeback stage, zero-latency, highest priority;
  - secondary: multi-cycle unit (div/mem), buffered in a small FIFO, valid/ready handshake.
- Sits between the WB stage / multi-cycle unit and the register file write inputs (write_data, write_reg, RegWrite).
- A starvation guard forces the secondary through after a bounded number of primary wins, stalling WB for that cycle.

---
 rtl/rf_arb_pkg.sv | 15 +
 rtl/rf_arb_fifo.sv | 94 +++++++++
 rtl/rf_write_arbiter.sv | 131 +++++++++++++
 tb/tb_rf_write_arbiter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// Shared constants and grant-source encoding for the register-file write arbiter.
package rf_arb_pkg;

  localparam int unsigned REG_ADDR_W                = 5;
  localparam logic [REG_ADDR_W-1:0] REG_X0          = 5'd0;
  localparam int unsigned RF_ARB_DEFAULT_DEPTH      = 2;
  localparam int unsigned RF_ARB_DEFAULT_STARVE_MAX = 4;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WB   = 2'd1,
    GNT_MU   = 2'd2
  } gnt_src_e;

endpackage

// File: rtl/rf_arb_fifo.sv
// Synchronous FIFO of {rd, data} for the secondary writer.
// With RF_ARB_PENDING_CHECK_EN it also exposes a per-entry rd/valid view.
module rf_arb_fifo
  import rf_arb_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = RF_ARB_DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [REG_ADDR_W-1:0]    push_rd,
  input  logic [N-1:0]             push_data,
  input  logic                     pop,
  output logic [REG_ADDR_W-1:0]    head_rd,
  output logic [N-1:0]             head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
`ifdef RF_ARB_PENDING_CHECK_EN
  ,
  output logic [DEPTH-1:0]                 ent_vld,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_rd
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = REG_ADDR_W + N;

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Pointer, occupancy and storage next-state; pop is only issued when non-empty.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {push_rd, push_data};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; validity is tracked by the occupancy counter.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign {head_rd, head_data} = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

`ifdef RF_ARB_PENDING_CHECK_EN
  // Entry i is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    logic [PW-1:0] off;
    off     = '0;
    ent_vld = '0;
    ent_rd  = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      off        = PW'(PW'(i) - rd_ptr_q);
      ent_vld[i] = (CW'(off) < count_q);
      ent_rd[i]  = mem_q[i][EW-1 -: REG_ADDR_W];
    end
  end
`endif

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between WB (priority) and a buffered
// multi-cycle unit, with a starvation guard. RF_ARB_PENDING_CHECK_EN adds rd hazard lookups.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned N          = 32,
  parameter int unsigned DEPTH      = RF_ARB_DEFAULT_DEPTH,
  parameter int unsigned STARVE_MAX = RF_ARB_DEFAULT_STARVE_MAX
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_we,
  input  logic [REG_ADDR_W-1:0]  wb_rd,
  input  logic [N-1:0]           wb_data,
  output logic                   wb_stall,
  input  logic                   mu_valid,
  input  logic [REG_ADDR_W-1:0]  mu_rd,
  input  logic [N-1:0]           mu_data,
  output logic                   mu_ready,
  output logic                   rf_we,
  output logic [REG_ADDR_W-1:0]  rf_waddr,
  output logic [N-1:0]           rf_wdata,
  output logic [$clog2(DEPTH):0] buf_count
`ifdef RF_ARB_PENDING_CHECK_EN
  ,
  input  logic [REG_ADDR_W-1:0]  chk_rs1,
  input  logic [REG_ADDR_W-1:0]  chk_rs2,
  output logic                   chk_hit1,
  output logic                   chk_hit2
`endif
);

  localparam int unsigned CW   = $clog2(DEPTH) + 1;
  localparam int unsigned SC_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic                  wp;
  logic                  force_mu;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [N-1:0]          head_data;
  gnt_src_e              gnt;
  logic [SC_W-1:0]       starve_q, starve_d;

`ifdef RF_ARB_PENDING_CHECK_EN
  logic [DEPTH-1:0]                 ent_vld;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_rd;
`endif

  assign wp        = wb_we && (wb_rd != REG_X0);
  assign force_mu  = (starve_q == SC_W'(STARVE_MAX)) && !fifo_empty;
  assign mu_ready  = !rst && !fifo_full;
  assign fifo_push = mu_valid && mu_ready && (mu_rd != REG_X0);
  assign fifo_pop  = (gnt == GNT_MU);

  rf_arb_fifo #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_rd   (mu_rd),
    .push_data (mu_data),
    .pop       (fifo_pop),
    .head_rd   (head_rd),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
`ifdef RF_ARB_PENDING_CHECK_EN
    ,
    .ent_vld   (ent_vld),
    .ent_rd    (ent_rd)
`endif
  );

  // Grant selection: forced secondary, then primary, then any buffered secondary.
  always_comb begin
    gnt = GNT_NONE;
    if (rst) begin
      gnt = GNT_NONE;
    end else if (force_mu) begin
      gnt = GNT_MU;
    end else if (wp) begin
      gnt = GNT_WB;
    end else if (!fifo_empty) begin
      gnt = GNT_MU;
    end
  end

  assign rf_we     = (gnt != GNT_NONE);
  assign rf_waddr  = (gnt == GNT_MU) ? head_rd : wb_rd;
  assign rf_wdata  = (gnt == GNT_MU) ? head_data : wb_data;
  assign wb_stall  = !rst && force_mu && wp;
  assign buf_count = rst ? '0 : fifo_count;

  // Count consecutive primary wins while the secondary waits; saturate at the limit.
  always_comb begin
    starve_d = starve_q;
    if ((gnt == GNT_MU) || fifo_empty) begin
      starve_d = '0;
    end else if ((gnt == GNT_WB) && (starve_q != SC_W'(STARVE_MAX))) begin
      starve_d = starve_q + SC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

`ifdef RF_ARB_PENDING_CHECK_EN
  // Hazard lookup against every live entry, including the head being popped now.
  always_comb begin
    chk_hit1 = 1'b0;
    chk_hit2 = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (ent_vld[i] && (ent_rd[i] == chk_rs1) && (chk_rs1 != REG_X0)) chk_hit1 = 1'b1;
      if (ent_vld[i] && (ent_rd[i] == chk_rs2) && (chk_rs2 != REG_X0)) chk_hit2 = 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: directed cycles push expected RF writes,
// a negedge monitor pops and compares them; side outputs are checked per cycle.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        wb_stall;
  logic        mu_valid = 1'b0;
  logic [4:0]  mu_rd = '0;
  logic [31:0] mu_data = '0;
  logic        mu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  buf_count;
`ifdef RF_ARB_PENDING_CHECK_EN
  logic [4:0]  chk_rs1 = '0;
  logic [4:0]  chk_rs2 = '0;
  logic        chk_hit1;
  logic        chk_hit2;
`endif

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q [$];

  rf_write_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .wb_stall  (wb_stall),
    .mu_valid  (mu_valid),
    .mu_rd     (mu_rd),
    .mu_data   (mu_data),
    .mu_ready  (mu_ready),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .buf_count (buf_count)
`ifdef RF_ARB_PENDING_CHECK_EN
    ,
    .chk_rs1   (chk_rs1),
    .chk_rs2   (chk_rs2),
    .chk_hit1  (chk_hit1),
    .chk_hit2  (chk_hit2)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented write must match the next expected one, and no expected write may be skipped.
  always @(negedge clk) begin
    logic [36:0] e;
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %0h expected no write at %0t",
                 rf_waddr, rf_wdata, $time);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 32'(rf_waddr), 32'(e[36:32]));
        check("write_data", rf_wdata, e[31:0]);
      end
    end else if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_write: got rf_we %0b expected addr %0d data %0h at %0t",
               rf_we, e[36:32], e[31:0], $time);
    end
  end

  // One clock cycle: drive inputs after the edge, queue the expected write, check side outputs mid-cycle.
  task automatic cyc(input logic r, input logic we, input logic [4:0] rd, input logic [31:0] d,
                     input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                     input logic ew, input logic [4:0] ea, input logic [31:0] ed,
                     input logic es, input logic erdy, input logic [1:0] ec);
    @(posedge clk);
    #1;
    rst = r; wb_we = we; wb_rd = rd; wb_data = d;
    mu_valid = mv; mu_rd = mrd; mu_data = md;
    if (ew) exp_q.push_back({ea, ed});
    @(negedge clk);
    check("wb_stall", 32'(wb_stall), 32'(es));
    check("mu_ready", 32'(mu_ready), 32'(erdy));
    check("buf_count", 32'(buf_count), 32'(ec));
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset: no write, stall 0, ready 0, count 0
    cyc(1, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0);
    cyc(1, 1, 5, 32'h1, 0, 0, 0,  0, 0, 0,  0, 0, 0);
    // zero-latency primary write
    cyc(0, 1, 5, 32'hDEADBEEF, 0, 0, 0,  1, 5, 32'hDEADBEEF,  0, 1, 0);
    // three secondary requests while WB is busy; third blocked until a pop
    cyc(0, 1, 7, 32'h70, 1, 1, 32'h11,  1, 7, 32'h70,  0, 1, 0);
    cyc(0, 1, 7, 32'h71, 1, 2, 32'h22,  1, 7, 32'h71,  0, 1, 1);
    cyc(0, 1, 7, 32'h72, 1, 3, 32'h33,  1, 7, 32'h72,  0, 0, 2);
    cyc(0, 1, 7, 32'h73, 1, 3, 32'h33,  1, 7, 32'h73,  0, 0, 2);
    cyc(0, 1, 7, 32'h74, 1, 3, 32'h33,  1, 7, 32'h74,  0, 0, 2);
    cyc(0, 1, 7, 32'h74, 1, 3, 32'h33,  1, 1, 32'h11,  1, 0, 2);
    cyc(0, 1, 7, 32'h75, 1, 3, 32'h33,  1, 7, 32'h75,  0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0,  1, 2, 32'h22,  0, 0, 2);
    cyc(0, 0, 0, 0, 0, 0, 0,  1, 3, 32'h33,  0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 1, 0);
    // starvation guard: rd=9 buffered, four WB wins, then forced with stall
    cyc(0, 0, 0, 0, 1, 9, 32'h99,  0, 0, 0,  0, 1, 0);
    cyc(0, 1, 7, 32'h80, 0, 0, 0,  1, 7, 32'h80,  0, 1, 1);
    cyc(0, 1, 7, 32'h81, 0, 0, 0,  1, 7, 32'h81,  0, 1, 1);
    cyc(0, 1, 7, 32'h82, 0, 0, 0,  1, 7, 32'h82,  0, 1, 1);
    cyc(0, 1, 7, 32'h83, 0, 0, 0,  1, 7, 32'h83,  0, 1, 1);
    cyc(0, 1, 7, 32'h84, 0, 0, 0,  1, 9, 32'h99,  1, 1, 1);
    cyc(0, 1, 7, 32'h84, 0, 0, 0,  1, 7, 32'h84,  0, 1, 0);
    // x0 on both sides: handshake completes, nothing buffered or written
    cyc(0, 0, 0, 0, 1, 0, 32'hBAD,  0, 0, 0,  0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 1, 0);
    cyc(0, 1, 0, 32'hBAD, 0, 0, 0,  0, 0, 0,  0, 1, 0);
    // simultaneous push and pop keeps occupancy and order
    cyc(0, 0, 0, 0, 1, 4, 32'h44,  0, 0, 0,  0, 1, 0);
    cyc(0, 0, 0, 0, 1, 6, 32'h66,  1, 4, 32'h44,  0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0,  1, 6, 32'h66,  0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 1, 0);
    // fill two entries, reset mid-operation drops them
    cyc(0, 1, 7, 32'h90, 1, 10, 32'hA0,  1, 7, 32'h90,  0, 1, 0);
    cyc(0, 1, 7, 32'h91, 1, 11, 32'hB0,  1, 7, 32'h91,  0, 1, 1);
    cyc(1, 1, 7, 32'h92, 0, 0, 0,  0, 0, 0,  0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 1, 0);
`ifdef RF_ARB_PENDING_CHECK_EN
    // pending check: rd=12 buffered behind WB, hit while live, clear after pop
    chk_rs1 = 5'd12; chk_rs2 = 5'd0;
    cyc(0, 1, 7, 32'hC0, 1, 12, 32'hCC,  1, 7, 32'hC0,  0, 1, 0);
    cyc(0, 1, 7, 32'hC1, 0, 0, 0,  1, 7, 32'hC1,  0, 1, 1);
    check("chk_hit1_live", 32'(chk_hit1), 32'd1);
    check("chk_hit2_x0", 32'(chk_hit2), 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0,  1, 12, 32'hCC,  0, 1, 1);
    check("chk_hit1_popping", 32'(chk_hit1), 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 1, 0);
    check("chk_hit1_cleared", 32'(chk_hit1), 32'd0);
`endif
    @(posedge clk);
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
